// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road phase sequencer with all-red clearance, tick prescaler and pedestrian shortening
module traffic_phase_ctrl #(
    parameter int TICK_DIV     = 50000000,
    parameter int TIME_W       = 5,
    parameter int GREEN_TIME   = 16,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int PED_TIME     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              set,
    input  logic              ped_req,
    output logic [1:0]        light_ns,
    output logic [1:0]        light_ew,
    output logic [TIME_W-1:0] light_time,
    output logic [2:0]        current_state,
    output logic              ped_walk,
    output logic              feedback
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [TIME_W-1:0] G = TIME_W'(GREEN_TIME == 0 ? 1 : GREEN_TIME);
    localparam logic [TIME_W-1:0] Y = TIME_W'(YELLOW_TIME == 0 ? 1 : YELLOW_TIME);
    localparam logic [TIME_W-1:0] R = TIME_W'(ALL_RED_TIME == 0 ? 1 : ALL_RED_TIME);
    localparam logic [TIME_W-1:0] P = TIME_W'(PED_TIME == 0 ? 1 : PED_TIME);

    typedef enum logic [2:0] {NS_GREEN, NS_YELLOW, RED_A, EW_GREEN, EW_YELLOW, RED_B} phase_t;

    phase_t            state, state_n, nxt;
    logic [PW-1:0]     presc, presc_n;
    logic [TIME_W-1:0] time_n, nxt_dur;
    logic              ped_pending, pend_n, walk_n, fb_n, tick, green, nxt_red;
    logic [1:0]        ns_n, ew_n;

    assign current_state = state;

    // state register and registered outputs; async active-low reset lands on NS_GREEN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= NS_GREEN;
            light_time  <= G;
            presc       <= '0;
            ped_pending <= 1'b0;
            ped_walk    <= 1'b0;
            feedback    <= 1'b0;
            light_ns    <= 2'b10;
            light_ew    <= 2'b00;
        end else begin
            state       <= state_n;
            light_time  <= time_n;
            presc       <= presc_n;
            ped_pending <= pend_n;
            ped_walk    <= walk_n;
            feedback    <= fb_n;
            light_ns    <= ns_n;
            light_ew    <= ew_n;
        end
    end

    // next phase, its duration, and the tick/countdown/pedestrian rules
    always_comb begin
        state_n = state;
        time_n  = light_time;
        presc_n = presc;
        pend_n  = ped_pending | ped_req;
        walk_n  = ped_walk;
        fb_n    = 1'b0;
        tick    = presc == PW'(TICK_DIV - 1);
        green   = state == NS_GREEN || state == EW_GREEN;
        case (state)
            NS_GREEN:  nxt = NS_YELLOW;
            NS_YELLOW: nxt = RED_A;
            RED_A:     nxt = EW_GREEN;
            EW_GREEN:  nxt = EW_YELLOW;
            EW_YELLOW: nxt = RED_B;
            default:   nxt = NS_GREEN;
        endcase
        nxt_red = nxt == RED_A || nxt == RED_B;
        nxt_dur = nxt_red ? R : (nxt == NS_YELLOW || nxt == EW_YELLOW) ? Y : G;
        if (!enb) begin
            state_n = NS_GREEN;
            time_n  = G;
            presc_n = '0;
            pend_n  = 1'b0;
            walk_n  = 1'b0;
        end else if (state > RED_B) begin
            state_n = NS_GREEN;
            time_n  = G;
            walk_n  = 1'b0;
        end else if (set) begin
            presc_n = tick ? '0 : presc + 1'b1;
            if (tick) begin
                if (light_time <= TIME_W'(1)) begin
                    state_n = nxt;
                    time_n  = nxt_dur;
                    fb_n    = 1'b1;
                    walk_n  = nxt_red & ped_pending;
                    pend_n  = nxt_red ? ped_req : pend_n;
                end else begin
                    time_n = (green && pend_n && light_time > P) ? P : light_time - 1'b1;
                end
            end
        end
        ns_n = state_n == NS_GREEN ? 2'b10 : state_n == NS_YELLOW ? 2'b01 : 2'b00;
        ew_n = state_n == EW_GREEN ? 2'b10 : state_n == EW_YELLOW ? 2'b01 : 2'b00;
    end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: randomized and directed checks of two prescaler variants against a phase-table model
module tb_traffic_phase_ctrl;
    localparam int G = 5, Y = 2, R = 1, P = 2;
    localparam logic [13:0] RST_EXP = {2'b10, 2'b00, 5'd5, 3'd0, 1'b0, 1'b0};

    logic clk = 0, rst = 0, enb = 1, set = 1, ped_req = 0;
    logic [1:0] a_ns, a_ew, b_ns, b_ew;
    logic [4:0] a_time, b_time;
    logic [2:0] a_st, b_st;
    logic a_walk, a_fb, b_walk, b_fb;
    logic [13:0] obs_a, obs_b;
    int checks = 0, failures = 0;

    typedef struct packed {
        logic [2:0] ph;
        logic [4:0] rem;
        logic [2:0] cnt;
        logic pend, walk, fb;
    } mdl_t;

    mdl_t ma, mb;
    int dur [6] = '{G, Y, R, G, Y, R};
    logic [1:0] ns_tab [6] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] ew_tab [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};

    traffic_phase_ctrl #(.TICK_DIV(1), .TIME_W(5), .GREEN_TIME(G), .YELLOW_TIME(Y),
                         .ALL_RED_TIME(R), .PED_TIME(P)) dut_a (
        .clk(clk), .rst(rst), .enb(enb), .set(set), .ped_req(ped_req),
        .light_ns(a_ns), .light_ew(a_ew), .light_time(a_time), .current_state(a_st),
        .ped_walk(a_walk), .feedback(a_fb));

    traffic_phase_ctrl #(.TICK_DIV(4), .TIME_W(5), .GREEN_TIME(G), .YELLOW_TIME(Y),
                         .ALL_RED_TIME(R), .PED_TIME(P)) dut_b (
        .clk(clk), .rst(rst), .enb(enb), .set(set), .ped_req(ped_req),
        .light_ns(b_ns), .light_ew(b_ew), .light_time(b_time), .current_state(b_st),
        .ped_walk(b_walk), .feedback(b_fb));

    assign obs_a = {a_ns, a_ew, a_time, a_st, a_walk, a_fb};
    assign obs_b = {b_ns, b_ew, b_time, b_st, b_walk, b_fb};

    always #5 clk = ~clk;

    function automatic mdl_t init();
        mdl_t m;
        m = '0;
        m.rem = 5'(G);
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, int div);
        mdl_t n;
        n = m;
        n.fb = 0;
        if (!enb) return init();
        n.pend = m.pend | ped_req;
        if (set) begin
            if (int'(m.cnt) == div - 1) begin
                n.cnt = 0;
                if (m.rem == 1) begin
                    n.ph  = m.ph == 5 ? 3'd0 : m.ph + 3'd1;
                    n.rem = 5'(dur[n.ph]);
                    n.fb  = 1;
                    n.walk = (n.ph == 2 || n.ph == 5) ? m.pend : 1'b0;
                    if (n.ph == 2 || n.ph == 5) n.pend = ped_req;
                end else if ((m.ph == 0 || m.ph == 3) && (m.pend || ped_req) && m.rem > P)
                    n.rem = 5'(P);
                else
                    n.rem = m.rem - 5'd1;
            end else n.cnt = m.cnt + 3'd1;
        end
        return n;
    endfunction

    function automatic logic [13:0] expv(mdl_t m);
        return {ns_tab[m.ph], ew_tab[m.ph], m.rem, m.ph, m.walk, m.fb};
    endfunction

    always @(posedge clk or negedge rst)
        if (!rst) begin
            ma <= init();
            mb <= init();
        end else begin
            ma <= step(ma, 1);
            mb <= step(mb, 4);
        end

    task automatic do_reset();
        rst = 0;
        #2;
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (obs_a !== RST_EXP) begin failures++; $display("FAIL reset_a got=%h exp=%h", obs_a, RST_EXP); end
        checks++; if (obs_b !== RST_EXP) begin failures++; $display("FAIL reset_b got=%h exp=%h", obs_b, RST_EXP); end
        rst = 1;
    endtask

    task automatic test_sequence();
        int fbcnt = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            fbcnt += int'(a_fb);
            checks++; if (obs_a !== expv(ma)) begin failures++; $display("FAIL seq_a cyc=%0d got=%h exp=%h", i, obs_a, expv(ma)); end
            checks++; if (obs_b !== expv(mb)) begin failures++; $display("FAIL seq_b cyc=%0d got=%h exp=%h", i, obs_b, expv(mb)); end
            if (i == 4) begin
                checks++; if (a_time !== 5'd1) begin failures++; $display("FAIL seq_time1 got=%0d exp=1", a_time); end
                checks++; if (b_time !== 5'd4) begin failures++; $display("FAIL div4_time got=%0d exp=4", b_time); end
            end
            if (i == 5) begin
                checks++; if ({a_st, a_time} !== {3'd1, 5'd2}) begin failures++; $display("FAIL seq_yellow got=%0d/%0d exp=1/2", a_st, a_time); end
            end
        end
        checks++; if ({a_st, a_time} !== {3'd0, 5'd5}) begin failures++; $display("FAIL seq_wrap got=%0d/%0d exp=0/5", a_st, a_time); end
        checks++; if (fbcnt != 6) begin failures++; $display("FAIL seq_fbcount got=%0d exp=6", fbcnt); end
    endtask

    task automatic test_ped();
        int k;
        do_reset();
        @(posedge clk); #1;
        ped_req = 1;
        @(posedge clk); #1;
        ped_req = 0;
        checks++; if (a_time !== 5'd2) begin failures++; $display("FAIL ped_shorten got=%0d exp=2", a_time); end
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            checks++; if (obs_a !== expv(ma)) begin failures++; $display("FAIL ped_a got=%h exp=%h", obs_a, expv(ma)); end
            checks++; if (obs_b !== expv(mb)) begin failures++; $display("FAIL ped_b got=%h exp=%h", obs_b, expv(mb)); end
            if (a_st == 3'd2) begin
                checks++; if (a_walk !== 1'b1) begin failures++; $display("FAIL ped_walk_reda got=%b exp=1", a_walk); end
            end
            if (a_st == 3'd5) begin
                checks++; if (a_walk !== 1'b0) begin failures++; $display("FAIL ped_walk_redb got=%b exp=0", a_walk); end
            end
        end
        for (k = 0; k < 40 && !(a_st == 3'd3 && a_time == 5'd2); k++) begin
            @(posedge clk); #1;
        end
        checks++; if (!(a_st == 3'd3 && a_time == 5'd2)) begin failures++; $display("FAIL ped_ew_wait got=%0d/%0d exp=3/2", a_st, a_time); end
        ped_req = 1;
        @(posedge clk); #1;
        ped_req = 0;
        checks++; if (a_time !== 5'd1) begin failures++; $display("FAIL ped_noshorten got=%0d exp=1", a_time); end
        for (k = 0; k < 10 && a_st != 3'd5; k++) begin
            @(posedge clk); #1;
        end
        checks++; if ({a_st, a_walk} !== {3'd5, 1'b1}) begin failures++; $display("FAIL ped_walk_redb2 got=%0d/%b exp=5/1", a_st, a_walk); end
    endtask

    task automatic test_freeze();
        logic [13:0] snap;
        int k;
        for (k = 0; k < 40 && !(a_st == 3'd1 && a_time == 5'd2); k++) begin
            @(posedge clk); #1;
        end
        checks++; if (!(a_st == 3'd1 && a_time == 5'd2)) begin failures++; $display("FAIL frz_wait got=%0d/%0d exp=1/2", a_st, a_time); end
        snap = {obs_a[13:1], 1'b0};
        set = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (obs_a !== snap) begin failures++; $display("FAIL frz_hold got=%h exp=%h", obs_a, snap); end
            checks++; if (obs_b !== expv(mb)) begin failures++; $display("FAIL frz_b got=%h exp=%h", obs_b, expv(mb)); end
        end
        set = 1;
        @(posedge clk); #1;
        checks++; if ({a_st, a_time} !== {3'd1, 5'd1}) begin failures++; $display("FAIL frz_resume got=%0d/%0d exp=1/1", a_st, a_time); end
        checks++; if (obs_b !== expv(mb)) begin failures++; $display("FAIL frz_resume_b got=%h exp=%h", obs_b, expv(mb)); end
    endtask

    task automatic test_enb_rst();
        int k;
        for (k = 0; k < 40 && a_st != 3'd3; k++) begin
            @(posedge clk); #1;
        end
        enb = 0;
        @(posedge clk); #1;
        enb = 1;
        checks++; if (obs_a !== RST_EXP) begin failures++; $display("FAIL enb_a got=%h exp=%h", obs_a, RST_EXP); end
        checks++; if (obs_b !== RST_EXP) begin failures++; $display("FAIL enb_b got=%h exp=%h", obs_b, RST_EXP); end
        for (k = 0; k < 40 && a_st != 3'd5; k++) begin
            @(posedge clk); #1;
        end
        checks++; if (a_st !== 3'd5) begin failures++; $display("FAIL rst_wait got=%0d exp=5", a_st); end
        @(negedge clk); #2;
        rst = 0;
        #1;
        checks++; if (obs_a !== RST_EXP) begin failures++; $display("FAIL async_rst got=%h exp=%h", obs_a, RST_EXP); end
        rst = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            ped_req = $urandom_range(7) == 0;
            set     = $urandom_range(9) != 0;
            enb     = $urandom_range(79) != 0;
            @(posedge clk); #1;
            checks++; if (obs_a !== expv(ma)) begin failures++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", i, obs_a, expv(ma)); end
            checks++; if (obs_b !== expv(mb)) begin failures++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", i, obs_b, expv(mb)); end
        end
        ped_req = 0; set = 1; enb = 1;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_ped();
        test_freeze();
        test_enb_rst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
